// File: rtl/shift_operand_encoder.sv
// Iterative encoder that turns a 32-bit constant into the 12-bit shift_operand field.
// It searches the rotated 8-bit immediate form, or checks the sign-extended 12-bit offset form.
`timescale 1ns/1ps

module shift_operand_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value_in,
  input  logic        is_mem_command,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [11:0] shift_operand_out
);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  state_t      state, state_next;
  logic [3:0]  rot_cnt, rot_cnt_next;
  logic [31:0] value_q, value_next;
  logic        found_next;
  logic [11:0] out_next;

  logic [5:0]  rot_amt;
  logic [31:0] rotated;
  logic        hit;
  logic        mem_ok;

  // Rotating left by 2r undoes the decode-side rotate right, so the
  // immediate must then sit entirely in the low byte.
  assign rot_amt = {1'b0, rot_cnt, 1'b0};
  assign rotated = (value_q << rot_amt) | (value_q >> (6'd32 - rot_amt));
  assign hit     = (rotated[31:8] == 24'd0);

  // Offset form is legal when bits [31:11] are pure sign extension of bit 11.
  assign mem_ok  = (&value_in[31:11]) | ~(|value_in[31:11]);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned and infers a latch.
    state_next   = state;
    rot_cnt_next = rot_cnt;
    value_next   = value_q;
    found_next   = found;
    out_next     = shift_operand_out;

    case (state)
      IDLE: begin
        if (start) begin
          value_next   = value_in;
          rot_cnt_next = 4'd0;
          if (is_mem_command) begin
            state_next = DONE;
            found_next = mem_ok;
            out_next   = mem_ok ? value_in[11:0] : 12'd0;
          end else begin
            state_next = SEARCH;
            found_next = 1'b0;
            out_next   = 12'd0;
          end
        end
      end

      SEARCH: begin
        if (hit) begin
          found_next = 1'b1;
          out_next   = {rot_cnt, rotated[7:0]};
          state_next = DONE;
        end else if (rot_cnt == 4'd15) begin
          found_next = 1'b0;
          out_next   = 12'd0;
          state_next = DONE;
        end else begin
          rot_cnt_next = rot_cnt + 4'd1;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
    if (rst) begin
      state             <= IDLE;
      rot_cnt           <= 4'd0;
      value_q           <= 32'd0;
      found             <= 1'b0;
      shift_operand_out <= 12'd0;
    end else begin
      state             <= state_next;
      rot_cnt           <= rot_cnt_next;
      value_q           <= value_next;
      found             <= found_next;
      shift_operand_out <= out_next;
    end
  end

endmodule
